// File: rtl/io_reader_pkg.sv
// Shared types and default widths for the board input reader.
// Event record layout: {kind, key mask, switch snapshot}.
package io_reader_pkg;

    localparam int SW_W_DEFAULT  = 18;
    localparam int KEY_W_DEFAULT = 4;

    typedef enum logic {
        EV_PRESS   = 1'b0,
        EV_RELEASE = 1'b1
    } ev_kind_e;

    typedef struct packed {
        ev_kind_e                   kind;
        logic [KEY_W_DEFAULT-1:0]   keys;
        logic [SW_W_DEFAULT-1:0]    sw;
    } io_event_t;

endpackage

// File: rtl/io_input_reader_debounce.sv
// in_debounce: 2-flop synchroniser, run-length counter and stable register for one
// signal group; upd is a combinational strobe asserted on the edge that updates stable.
module in_debounce #(
    parameter int             W               = 1,
    parameter int             DEBOUNCE_CYCLES = 4,
    parameter logic [W-1:0]   RST_VAL         = {W{1'b0}}
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  stable,
    output logic          upd
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [W-1:0]     meta_r;
    logic [W-1:0]     sync_r;
    logic [W-1:0]     prev_r;
    logic [W-1:0]     stable_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_inc_s;
    logic             diff_s;
    logic             changed_s;
    logic             upd_s;

    // Next count value and acceptance strobe; a fresh change restarts the run at 1.
    always_comb begin
        diff_s    = (sync_r != stable_r);
        changed_s = (sync_r != prev_r);
        if (changed_s) begin
            cnt_inc_s = CNT_W'(1);
        end else begin
            cnt_inc_s = cnt_r + CNT_W'(1);
        end
        upd_s = diff_s && (cnt_inc_s == CNT_W'(DEBOUNCE_CYCLES));
    end

    // Synchroniser, previous-sample tracker, counter and stable register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_r   <= RST_VAL;
            sync_r   <= RST_VAL;
            prev_r   <= RST_VAL;
            stable_r <= RST_VAL;
            cnt_r    <= {CNT_W{1'b0}};
        end else begin
            meta_r <= din;
            sync_r <= meta_r;
            prev_r <= sync_r;
            if (!diff_s) begin
                cnt_r <= {CNT_W{1'b0}};
            end else if (upd_s) begin
                cnt_r    <= {CNT_W{1'b0}};
                stable_r <= sync_r;
            end else begin
                cnt_r <= cnt_inc_s;
            end
        end
    end

    assign stable = stable_r;
    assign upd    = upd_s;

endmodule

// File: rtl/io_input_reader.sv
// io_input_reader: debounced KEY/SW receiver with a 1-deep hold-oldest event register.
// Define IO_READER_RELEASE_EN to also report key releases as kind-1 events.
module io_input_reader
    import io_reader_pkg::*;
#(
    parameter int SW_W            = SW_W_DEFAULT,
    parameter int KEY_W           = KEY_W_DEFAULT,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [KEY_W-1:0]         KEY,
    input  logic [SW_W-1:0]          SW,
    output logic [SW_W-1:0]          sw_value,
    output logic [KEY_W-1:0]         key_level,
    output logic [KEY_W-1:0]         key_press,
    output logic                     ev_valid,
    input  logic                     ev_ready,
    output logic [KEY_W+SW_W:0]      ev_data,
    output logic                     overflow,
    input  logic                     ovf_clr
);

    localparam int EV_W = 1 + KEY_W + SW_W;

    logic [KEY_W-1:0] key_stable_s;
    logic [KEY_W-1:0] key_upd_s;
    logic [SW_W-1:0]  sw_stable_s;
    logic             sw_upd_s;
    logic [KEY_W-1:0] key_press_r;
    logic             sw_upd_r;
    logic             ev_valid_r;
    logic [EV_W-1:0]  ev_data_r;
    logic             overflow_r;
    logic             hs_s;
    logic             press_ev_s;
    logic             rel_ev_s;
    logic [KEY_W-1:0] rel_mask_s;
    ev_kind_e         kind_s;
    logic [KEY_W-1:0] mask_s;
    logic             load_s;
    logic             drop_s;

    for (genvar i = 0; i < KEY_W; i++) begin : g_key
        in_debounce #(
            .W(1), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RST_VAL(1'b1)
        ) u_key_db (
            .clk(clk), .rst_n(rst_n), .din(KEY[i]),
            .stable(key_stable_s[i]), .upd(key_upd_s[i])
        );
    end

    in_debounce #(
        .W(SW_W), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RST_VAL({SW_W{1'b0}})
    ) u_sw_db (
        .clk(clk), .rst_n(rst_n), .din(SW),
        .stable(sw_stable_s), .upd(sw_upd_s)
    );

    // Edge pulses line up with the stable-register update; a press is stable 1 about to become 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key_press_r <= {KEY_W{1'b0}};
            sw_upd_r    <= 1'b0;
        end else begin
            key_press_r <= key_upd_s & key_stable_s;
            sw_upd_r    <= sw_upd_s;
        end
    end

`ifdef IO_READER_RELEASE_EN
    logic [KEY_W-1:0] key_rel_r;

    // Release pulses: stable 0 about to become 1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key_rel_r <= {KEY_W{1'b0}};
        end else begin
            key_rel_r <= key_upd_s & ~key_stable_s;
        end
    end

    assign rel_mask_s = key_rel_r;
    assign rel_ev_s   = |key_rel_r;
`else
    assign rel_mask_s = {KEY_W{1'b0}};
    assign rel_ev_s   = 1'b0;
`endif

    // Event selection: press/switch events beat a simultaneous release, which is then dropped.
    always_comb begin
        hs_s       = ev_valid_r && ev_ready;
        press_ev_s = (|key_press_r) || sw_upd_r;
        if (!press_ev_s && rel_ev_s) begin
            kind_s = EV_RELEASE;
            mask_s = rel_mask_s;
        end else begin
            kind_s = EV_PRESS;
            mask_s = key_press_r;
        end
        load_s = (press_ev_s || rel_ev_s) && (!ev_valid_r || hs_s);
        drop_s = ((press_ev_s || rel_ev_s) && ev_valid_r && !hs_s)
                 || (press_ev_s && rel_ev_s);
    end

    // Hold-oldest event register and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ev_valid_r <= 1'b0;
            ev_data_r  <= {EV_W{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            if (load_s) begin
                ev_valid_r <= 1'b1;
                ev_data_r  <= {kind_s, mask_s, sw_stable_s};
            end else if (hs_s) begin
                ev_valid_r <= 1'b0;
            end else begin
                ev_valid_r <= ev_valid_r;
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else if (ovf_clr) begin
                overflow_r <= 1'b0;
            end else begin
                overflow_r <= overflow_r;
            end
        end
    end

    assign sw_value  = sw_stable_s;
    assign key_level = key_stable_s;
    assign key_press = key_press_r;
    assign ev_valid  = ev_valid_r;
    assign ev_data   = ev_data_r;
    assign overflow  = overflow_r;

endmodule
